branch_history_queue: RTL
=========================

BRANCH_HISTORY_QUEUE -- requirements
Module: branch_history_queue

Interface
REQ-001 SHALL have parameters: DEPTH, default 4, number of in-flight branch entries (power of 2); HIST_W, default 3, global history width; PC_W, default 10, branch PC width.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous reset, active-low.
REQ-005 fetch_valid  in  1  conditional branch predicted at fetch this cycle.
REQ-006 fetch_pc  in  PC_W  PC of that branch.
REQ-007 prediction  in  1  taken/not-taken prediction from the prediction tables for fetch_pc.
REQ-008 fetch_ready  out  1  queue can accept a fetch entry this cycle.
REQ-009 ghr  out  HIST_W  speculative global history, drives the tables' prev_history.
REQ-010 resolve_valid  in  1  oldest in-flight branch resolved in execute.
REQ-011 resolve_taken  in  1  actual outcome of that branch.
REQ-012 we  out  1  table update strobe.
REQ-013 branch_taken  out  1  outcome for the update.
REQ-014 old_pc  out  PC_W  PC of the updated branch.
REQ-015 update_history  out  HIST_W  history captured when that branch was predicted.
REQ-016 mispredict  out  1  one-cycle pulse; pipeline redirect request.
REQ-017 count  out  $clog2(DEPTH)+1  occupied entries.
REQ-018 underflow  out  1  sticky error: resolve arrived while the queue was empty.

Function
REQ-019 Entry SHALL hold {pc, hist, pred}; storage circular, head/tail pointers wrap modulo DEPTH.
REQ-020 Push SHALL occur when fetch_valid && fetch_ready; entry = {fetch_pc, ghr, prediction}; ghr <= {ghr[HIST_W-2:0], prediction} the same edge.
REQ-021 fetch_ready SHALL be (count < DEPTH) && state==NORMAL; same-cycle pop SHALL NOT free a slot for push.
REQ-022 Pop SHALL occur when resolve_valid && count>0; arch_ghr <= {arch_ghr[HIST_W-2:0], resolve_taken}.
REQ-023 Update outputs SHALL be registered: one cycle after pop, we=1, old_pc=head.pc, update_history=head.hist, branch_taken=resolve_taken; otherwise we=0 and other update outputs hold.
REQ-024 Mispredict (pop with resolve_taken != head.pred) SHALL: assert mispredict at the same edge as we; empty the queue (count=0, head=tail); set ghr <= {arch_ghr[HIST_W-2:0], resolve_taken}; drop any same-cycle push without shifting ghr; enter RECOVER.
REQ-025 FSM states NORMAL, RECOVER: NORMAL->RECOVER on mispredict; RECOVER->NORMAL unconditionally after one cycle; fetch_ready=0 in RECOVER.
REQ-026 Simultaneous push and correct-prediction pop SHALL leave count unchanged; both pointers advance.
REQ-027 resolve_valid with count==0 SHALL be ignored (no we, no history change) and SHALL set underflow until reset.
REQ-028 fetch_valid with fetch_ready==0 SHALL be ignored; ghr unchanged.

Reset
REQ-029 On rst low, asynchronously: count=0, head=tail=0, ghr=0, arch_ghr=0, we=0, branch_taken=0, old_pc=0, update_history=0, mispredict=0, underflow=0, state=NORMAL.
REQ-030 Reset mid-operation SHALL discard all entries; entry storage need not be cleared.
REQ-031 First push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-032 Shared package bp_pkg SHALL hold HIST_W, PC_W, DEPTH defaults, the entry struct typedef and the FSM state enum.
REQ-033 Entry storage and pointer logic SHALL be one sub-module, bhq_fifo; history and FSM SHALL stay in the top.

Verification
REQ-034 After reset, push pc=0x012 pred=1, then pc=0x034 pred=0 -> ghr=3'b010, count=2.
REQ-035 Resolve first with taken=1 -> next cycle we=1, old_pc=0x012, update_history=3'b000, branch_taken=1, mispredict=0, count=1.
REQ-036 Four pushes pred=1 -> fetch_ready=0, count=4; fifth push ignored; ghr=3'b111.
REQ-037 Three entries, resolve head pred=1 with taken=0 while fetch_valid=1 -> mispredict=1, count=0, ghr={arch_ghr[1:0],0}, fetch_ready=0 for one cycle, then 1.
REQ-038 resolve_valid with count=0 -> we stays 0, underflow=1 until rst low.
REQ-039 rst low with count=3 -> count=0, ghr=0, fetch_ready=1 on the first cycle after rst high.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and default sizes for the branch history queue.
// Entry layout and recovery FSM states live here.
package bp_pkg;

   localparam int DEF_DEPTH  = 4;
   localparam int DEF_HIST_W = 3;
   localparam int DEF_PC_W   = 10;

   typedef struct packed {
      logic [DEF_PC_W-1:0]   pc;
      logic [DEF_HIST_W-1:0] hist;
      logic                  pred;
   } bhq_entry_t;

   typedef enum logic {
      NORMAL  = 1'b0,
      RECOVER = 1'b1
   } bhq_state_e;

endpackage

// File: rtl/bhq_fifo.sv
// Circular entry storage with head/tail pointers and occupancy count.
// A flush empties the queue by snapping head onto tail.
module bhq_fifo
   import bp_pkg::*;
#(
   parameter int  DEPTH = DEF_DEPTH,
   parameter type T     = bhq_entry_t
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  T                         i_din,
   output T                         o_head,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   T                r_mem [DEPTH];
   logic [AW-1:0]   r_head;
   logic [AW-1:0]   r_tail;
   logic [AW:0]     r_count;
   logic [AW:0]     w_inc;
   logic [AW:0]     w_dec;

   assign o_head  = r_mem[r_head];
   assign o_count = r_count;
   assign w_inc   = {{AW{1'b0}}, i_push};
   assign w_dec   = {{AW{1'b0}}, i_pop};

   // Storage is not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_tail] <= i_din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= r_tail;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_tail <= r_tail + AW'(1);
         end
         if (i_pop) begin
            r_head <= r_head + AW'(1);
         end
         r_count <= r_count + w_inc - w_dec;
      end
   end

endmodule

// File: rtl/branch_history_queue.sv
// In-flight branch queue: speculative/architectural global history,
// table update strobes and mispredict recovery.
module branch_history_queue
   import bp_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int HIST_W = DEF_HIST_W,
   parameter int PC_W   = DEF_PC_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch_valid,
   input  logic [PC_W-1:0]          fetch_pc,
   input  logic                     prediction,
   output logic                     fetch_ready,
   output logic [HIST_W-1:0]        ghr,
   input  logic                     resolve_valid,
   input  logic                     resolve_taken,
   output logic                     we,
   output logic                     branch_taken,
   output logic [PC_W-1:0]          old_pc,
   output logic [HIST_W-1:0]        update_history,
   output logic                     mispredict,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     underflow
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [HIST_W-1:0] hist;
      logic              pred;
   } ent_t;

   bhq_state_e          r_state;
   logic [HIST_W-1:0]   r_ghr;
   logic [HIST_W-1:0]   r_arch_ghr;
   logic                r_we;
   logic                r_taken;
   logic [PC_W-1:0]     r_old_pc;
   logic [HIST_W-1:0]   r_upd_hist;
   logic                r_mispredict;
   logic                r_underflow;

   logic [CW-1:0]       w_count;
   logic                w_ready;
   logic                w_push;
   logic                w_pop;
   logic                w_mis;
   ent_t                w_head;
   ent_t                w_din;

   assign w_ready = (w_count < FULL) && (r_state == NORMAL);
   assign w_push  = fetch_valid && w_ready;
   assign w_pop   = resolve_valid && (w_count != '0);
   assign w_mis   = w_pop && (resolve_taken != w_head.pred);
   assign w_din   = '{pc: fetch_pc, hist: r_ghr, pred: prediction};

   // A mispredict squashes any push arriving in the same cycle.
   bhq_fifo #(
      .DEPTH (DEPTH),
      .T     (ent_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push && !w_mis),
      .i_pop   (w_pop),
      .i_flush (w_mis),
      .i_din   (w_din),
      .o_head  (w_head),
      .o_count (w_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= NORMAL;
         r_ghr        <= '0;
         r_arch_ghr   <= '0;
         r_we         <= 1'b0;
         r_taken      <= 1'b0;
         r_old_pc     <= '0;
         r_upd_hist   <= '0;
         r_mispredict <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         r_we         <= w_pop;
         r_mispredict <= w_mis;
         if (w_pop) begin
            r_arch_ghr <= {r_arch_ghr[HIST_W-2:0], resolve_taken};
            r_old_pc   <= w_head.pc;
            r_upd_hist <= w_head.hist;
            r_taken    <= resolve_taken;
         end
         if (resolve_valid && (w_count == '0)) begin
            r_underflow <= 1'b1;
         end
         // Recovery restarts speculation from the resolved history.
         if (w_mis) begin
            r_ghr <= {r_arch_ghr[HIST_W-2:0], resolve_taken};
         end else if (w_push) begin
            r_ghr <= {r_ghr[HIST_W-2:0], prediction};
         end
         unique case (r_state)
            NORMAL:  r_state <= w_mis ? RECOVER : NORMAL;
            RECOVER: r_state <= NORMAL;
            default: r_state <= NORMAL;
         endcase
      end
   end

   assign fetch_ready    = w_ready;
   assign ghr            = r_ghr;
   assign we             = r_we;
   assign branch_taken   = r_taken;
   assign old_pc         = r_old_pc;
   assign update_history = r_upd_hist;
   assign mispredict     = r_mispredict;
   assign count          = w_count;
   assign underflow      = r_underflow;

endmodule
